// File: rtl/ball_sched_pkg.sv
// rtl/ball_sched_pkg.sv - shared FSM state, size type and scoring constants for ball_split_scheduler
package ball_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_KILL,
    ST_SPAWN_L,
    ST_SPAWN_R
  } sched_state_t;

  typedef logic [1:0] ball_size_t;

  localparam ball_size_t MAX_SIZE       = 2'd3;
  localparam int         SCORE_PER_SIZE = 10;

  // Smaller balls are worth more: 10 * (4 - size).
  function automatic logic [15:0] split_points(input ball_size_t s);
    return 16'(SCORE_PER_SIZE) * (16'(MAX_SIZE) + 16'd1 - 16'(s));
  endfunction

endpackage

// File: rtl/free_slot_encoder.sv
// rtl/free_slot_encoder.sv - lowest-index free slot finder with none-free flag
module free_slot_encoder #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
) (
  input  logic [NUM_SLOTS-1:0] active_i,
  output logic [SLOT_W-1:0]    free_slot_o,
  output logic                 none_free_o
);

  // Scanning downward lets the lowest free index win.
  always_comb begin
    free_slot_o = '0;
    none_free_o = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_i[i]) begin
        free_slot_o = SLOT_W'(i);
        none_free_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ball_split_scheduler.sv
// rtl/ball_split_scheduler.sv - ball slot pool: opening spawn, hit split/kill, level clear
// Optional macro SPLIT_SCORE_EN adds a saturating score output.
module ball_split_scheduler
  import ball_sched_pkg::*;
#(
  parameter int NUM_SLOTS    = 8,
  parameter int SLOT_W       = 3,
  parameter int SPLIT_OFFSET = 16,
  parameter int X_MAX        = 639
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 levelStart,
  input  logic [1:0]           startSize,
  input  logic [10:0]          startX,
  input  logic [10:0]          startY,
  input  logic                 hitValid,
  input  logic [SLOT_W-1:0]    hitSlot,
  input  logic [10:0]          hitX,
  input  logic [10:0]          hitY,
  output logic                 hitReady,
  output logic                 killValid,
  output logic [SLOT_W-1:0]    killSlot,
  output logic                 spawnValid,
  output logic [SLOT_W-1:0]    spawnSlot,
  output logic [10:0]          spawnX,
  output logic [10:0]          spawnY,
  output logic [1:0]           spawnSize,
  output logic                 spawnDirRight,
  output logic [NUM_SLOTS-1:0] slotActive,
  output logic                 levelClear,
  output logic [7:0]           overflowCnt
`ifdef SPLIT_SCORE_EN
  ,
  output logic [15:0]          score
`endif
);

  sched_state_t         state_q;
  logic [NUM_SLOTS-1:0] slot_active_q;
  ball_size_t           size_q [NUM_SLOTS];
  logic                 level_armed_q;
  logic                 level_clear_q;
  logic                 hit_ready_q;
  logic [10:0]          hit_x_q;
  logic [10:0]          hit_y_q;
  ball_size_t           hit_size_q;
  logic                 kill_valid_q;
  logic [SLOT_W-1:0]    kill_slot_q;
  logic                 spawn_valid_q;
  logic [SLOT_W-1:0]    spawn_slot_q;
  logic [10:0]          spawn_x_q;
  logic [10:0]          spawn_y_q;
  ball_size_t           spawn_size_q;
  logic                 spawn_dir_q;
  logic [7:0]           overflow_q;

  logic [SLOT_W-1:0]    free_slot;
  logic                 none_free;
  logic                 hit_accept_d;
  logic                 child_go_d;
  logic [10:0]          child_x_d;
  logic [11:0]          left_sum;
  logic [11:0]          right_sum;

  free_slot_encoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_free (
    .active_i    (slot_active_q),
    .free_slot_o (free_slot),
    .none_free_o (none_free)
  );

  assign hit_accept_d = hit_ready_q && hitValid && slot_active_q[hitSlot] && !levelStart;
  assign child_go_d   = ((state_q == ST_KILL) && (hit_size_q != '0)) || (state_q == ST_SPAWN_L);

  // 12-bit sums: bit 11 flags a negative left position.
  assign left_sum  = {1'b0, hit_x_q} - 12'(SPLIT_OFFSET);
  assign right_sum = {1'b0, hit_x_q} + 12'(SPLIT_OFFSET);

  always_comb begin
    child_x_d = '0;
    if (state_q == ST_KILL) begin
      child_x_d = left_sum[11] ? 11'd0 : left_sum[10:0];
    end else begin
      child_x_d = (right_sum > 12'(X_MAX)) ? 11'(X_MAX) : right_sum[10:0];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      slot_active_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) size_q[i] <= '0;
      level_armed_q <= 1'b0;
      level_clear_q <= 1'b0;
      hit_ready_q   <= 1'b1;
      hit_x_q       <= '0;
      hit_y_q       <= '0;
      hit_size_q    <= '0;
      kill_valid_q  <= 1'b0;
      kill_slot_q   <= '0;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_x_q     <= '0;
      spawn_y_q     <= '0;
      spawn_size_q  <= '0;
      spawn_dir_q   <= 1'b0;
      overflow_q    <= '0;
    end else begin
      kill_valid_q  <= 1'b0;
      spawn_valid_q <= 1'b0;
      if (levelStart) begin
        // The hit latch is reused to hold the opening ball until START.
        state_q       <= ST_START;
        slot_active_q <= '0;
        level_armed_q <= 1'b1;
        level_clear_q <= 1'b0;
        hit_ready_q   <= 1'b0;
        hit_x_q       <= startX;
        hit_y_q       <= startY;
        hit_size_q    <= startSize;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (level_armed_q && (slot_active_q == '0)) level_clear_q <= 1'b1;
            if (hit_accept_d) begin
              hit_x_q                <= hitX;
              hit_y_q                <= hitY;
              hit_size_q             <= size_q[hitSlot];
              kill_valid_q           <= 1'b1;
              kill_slot_q            <= hitSlot;
              slot_active_q[hitSlot] <= 1'b0;
              hit_ready_q            <= 1'b0;
              state_q                <= ST_KILL;
            end
          end
          ST_START: begin
            spawn_valid_q    <= 1'b1;
            spawn_slot_q     <= '0;
            spawn_x_q        <= hit_x_q;
            spawn_y_q        <= hit_y_q;
            spawn_size_q     <= hit_size_q;
            spawn_dir_q      <= 1'b1;
            slot_active_q[0] <= 1'b1;
            size_q[0]        <= hit_size_q;
            hit_ready_q      <= 1'b1;
            state_q          <= ST_IDLE;
          end
          ST_KILL: begin
            if (hit_size_q == '0) begin
              hit_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_SPAWN_L;
            end
          end
          ST_SPAWN_L: state_q <= ST_SPAWN_R;
          default: begin
            hit_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        endcase
        if (child_go_d) begin
          if (none_free) begin
            if (overflow_q != 8'hFF) overflow_q <= overflow_q + 8'd1;
          end else begin
            spawn_valid_q            <= 1'b1;
            spawn_slot_q             <= free_slot;
            spawn_x_q                <= child_x_d;
            spawn_y_q                <= hit_y_q;
            spawn_size_q             <= hit_size_q - 2'd1;
            spawn_dir_q              <= (state_q == ST_SPAWN_L);
            slot_active_q[free_slot] <= 1'b1;
            size_q[free_slot]        <= hit_size_q - 2'd1;
          end
        end
      end
    end
  end

`ifdef SPLIT_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_q} + {1'b0, split_points(size_q[hitSlot])};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_q <= '0;
    end else if (hit_accept_d) begin
      score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score = score_q;
`endif

  assign hitReady      = hit_ready_q;
  assign killValid     = kill_valid_q;
  assign killSlot      = kill_slot_q;
  assign spawnValid    = spawn_valid_q;
  assign spawnSlot     = spawn_slot_q;
  assign spawnX        = spawn_x_q;
  assign spawnY        = spawn_y_q;
  assign spawnSize     = spawn_size_q;
  assign spawnDirRight = spawn_dir_q;
  assign slotActive    = slot_active_q;
  assign levelClear    = level_clear_q;
  assign overflowCnt   = overflow_q;

endmodule
